piso_tx_ctrl: RTL and testbench

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

---
 rtl/piso_tx_ctrl_pkg.sv | 18 +
 rtl/parity_gen.sv | 11 +
 rtl/piso_tx_ctrl.sv | 104 ++++++++++
 tb/tb_piso_tx_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/piso_tx_ctrl_pkg.sv
// piso_tx_ctrl_pkg: state encoding and default word width for piso_tx_ctrl (PARITY state only with PISO_TX_CTRL_PARITY_EN).
package piso_tx_ctrl_pkg;
    localparam int DEFAULT_WIDTH = 7;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
`ifdef PISO_TX_CTRL_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd3;
`endif
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT
`ifdef PISO_TX_CTRL_PARITY_EN
        , PARITY = ST_PARITY
`endif
    } state_t;
endpackage

// File: rtl/parity_gen.sv
// parity_gen: even-parity XOR reduce of the held word, only built with PISO_TX_CTRL_PARITY_EN.
`ifdef PISO_TX_CTRL_PARITY_EN
module parity_gen #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH:0] data,
    output logic           parity
);
    assign parity = ^data;
endmodule
`endif

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: frames a word through an external PISO, MSB first; PISO_TX_CTRL_PARITY_EN appends an even-parity bit.
module piso_tx_ctrl
    import piso_tx_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [WIDTH:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           abort,
    output logic [WIDTH:0] piso_data,
    output logic           piso_en,
    output logic           piso_clr,
    input  logic           piso_serial,
    output logic           tx_out,
    output logic           tx_valid,
    output logic           done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] hold;
    logic abort_q;
    logic cancel;

`ifdef PISO_TX_CTRL_PARITY_EN
    logic par;
    parity_gen #(.WIDTH(WIDTH)) u_parity_gen (.data(hold), .parity(par));
`endif

    assign cancel    = abort && state != IDLE;
    assign piso_data = hold;
    assign piso_clr  = clr | abort_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            hold    <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_n;
            abort_q <= cancel;
            cnt     <= (state == SHIFT && cnt != LAST) ? cnt + 1'b1 : '0;
            if (in_valid && in_ready) hold <= in_data;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        piso_en  = 1'b1;
        tx_out   = 1'b0;
        tx_valid = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = LOAD;
            end
            LOAD: begin
                piso_en = 1'b0;
                state_n = SHIFT;
            end
            SHIFT: begin
                tx_valid = 1'b1;
                tx_out   = piso_serial;
                if (cnt == LAST) begin
`ifdef PISO_TX_CTRL_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = IDLE;
                    done    = 1'b1;
`endif
                end
            end
`ifdef PISO_TX_CTRL_PARITY_EN
            PARITY: begin
                tx_valid = 1'b1;
                tx_out   = par;
                done     = 1'b1;
                state_n  = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
        // a cancelled frame never reports completion
        if (cancel) begin
            state_n = IDLE;
            done    = 1'b0;
        end
        if (clr) begin
            in_ready = 1'b0;
            piso_en  = 1'b1;
            tx_out   = 1'b0;
            tx_valid = 1'b0;
            done     = 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: scoreboard bench for piso_tx_ctrl with a behavioural PISO; honours PISO_TX_CTRL_PARITY_EN.
module tb_piso_tx_ctrl;
    localparam int W = 7;
`ifdef PISO_TX_CTRL_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        int   cyc;
        logic b;
        logic d;
    } item_t;

    logic clk = 0;
    logic clr = 1;
    logic [W:0] in_data = '0;
    logic in_valid = 0;
    logic in_ready;
    logic abort = 0;
    logic [W:0] piso_data;
    logic piso_en, piso_clr, piso_serial, tx_out, tx_valid, done;
    logic [W:0] sr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int free_at = 0;
    int load_at = -1;
    bit started = 0;
    logic e_rdy, e_pclr, e_en, e_clr, e_abort, nx_pclr = 0;
    logic [W:0] e_hold = '0, nx_hold = '0;
    item_t q[$];

    piso_tx_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .piso_data(piso_data), .piso_en(piso_en), .piso_clr(piso_clr),
        .piso_serial(piso_serial), .tx_out(tx_out), .tx_valid(tx_valid), .done(done)
    );

    always #5 clk = ~clk;

    // external PISO: clear wins, en=0 loads, en=1 shifts toward the MSB
    always @(posedge clk)
        if (piso_clr) sr <= '0;
        else if (!piso_en) sr <= piso_data;
        else sr <= {sr[W-1:0], 1'b0};
    assign piso_serial = sr[W];

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    // one stimulus cycle; the model decides acceptance from frame-length arithmetic alone
    task automatic cycle(input logic v, input logic [W:0] d, input logic a, input logic c, output bit acc);
        bit idle;
        @(posedge clk);
        #1;
        cyc++;
        started = 1;
        e_hold  = nx_hold;
        e_pclr  = nx_pclr || c;
        in_valid = v;
        in_data  = d;
        abort    = a;
        clr      = c;
        idle    = !c && cyc >= free_at;
        acc     = idle && v;
        e_rdy   = idle;
        e_clr   = c;
        e_abort = a && !idle && !c;
        e_en    = c || cyc != load_at;
        nx_pclr = e_abort;
        if (c) begin
            free_at = cyc + 1;
            nx_hold = '0;
            load_at = -1;
        end else if (e_abort) begin
            free_at = cyc + 1;
        end else if (acc) begin
            nx_hold = d;
            load_at = cyc + 1;
            free_at = cyc + W + 3 + P;
            for (int i = 0; i <= W; i++) q.push_back('{cyc + 2 + i, d[W-i], (P == 0 && i == W)});
            if (P == 1) q.push_back('{cyc + 3 + W, ^d, 1'b1});
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", W'(in_ready), W'(e_rdy));
            chk("piso_clr", W'(piso_clr), W'(e_pclr));
            chk("piso_en", W'(piso_en), W'(e_en));
            if (!e_clr) chk("piso_data", piso_data, e_hold);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_bit cyc=%0d got=none exp_cyc=%0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (!e_clr && q.size() > 0 && q[0].cyc == cyc) begin
                item_t it;
                it = q.pop_front();
                chk("tx_valid", W'(tx_valid), W'(1));
                chk("tx_out", W'(tx_out), W'(it.b));
                chk("done", W'(done), W'(it.d && !e_abort));
            end else begin
                chk("tx_valid_idle", W'(tx_valid), W'(0));
                chk("done_idle", W'(done), W'(0));
            end
            if (e_clr || e_abort) q.delete();
        end
    end

    initial begin
        bit acc;
        int n;
        repeat (3) cycle(0, '0, 0, 1, acc);
        cycle(0, '0, 0, 0, acc);
        cycle(1, 8'hA5, 0, 0, acc);
        repeat (12) cycle(0, '0, 0, 0, acc);
        cycle(1, 8'h07, 0, 0, acc);
        repeat (12) cycle(0, '0, 0, 0, acc);
        cycle(1, 8'hFF, 0, 0, acc);
        repeat (4) cycle(0, '0, 0, 0, acc);
        cycle(0, '0, 1, 0, acc);
        repeat (4) cycle(0, '0, 0, 0, acc);
        n = 0;
        for (int i = 0; i < 26; i++) begin
            cycle(n < 2, (n == 0) ? 8'h01 : 8'h80, 0, 0, acc);
            n += int'(acc);
        end
        chk("b2b_accepts", W'(n), W'(2));
        repeat (12) cycle(0, '0, 0, 0, acc);
        cycle(1, 8'h5A, 0, 0, acc);
        repeat (3) cycle(0, '0, 0, 0, acc);
        cycle(0, '0, 0, 1, acc);
        repeat (3) cycle(0, '0, 0, 0, acc);
        cycle(1, 8'h3C, 1, 0, acc);
        repeat (12) cycle(0, '0, 0, 0, acc);
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 3) != 0, W'($urandom), ($urandom % 23) == 0, ($urandom % 97) == 0, acc);
        repeat (15) cycle(0, '0, 0, 0, acc);
        @(posedge clk);
        chk("queue_drained", W'(q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
